encoder_position: RTL and testbench
===================================

ENCODER_POSITION -- requirements
Module: encoder_position

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, the position register width.
REQ-002 SHALL provide parameter ERR_WIDTH, default 4, the error counter width.
REQ-003 SHALL provide parameter MIN_POS, default 0, the lower saturation bound (unused when WRAP=1).
REQ-004 SHALL provide parameter MAX_POS, default 255, the upper saturation bound (unused when WRAP=1).
REQ-005 SHALL provide parameter WRAP, default 0: 1 means position wraps modulo 2^WIDTH; 0 means position saturates at MIN_POS/MAX_POS.
REQ-006 SHALL provide parameter RESET_POS, default 0, the position after reset or clear.
REQ-007 SHALL provide parameter ACCEL_WINDOW, default 500000, the maximum clock cycles between two steps for them to count as "fast".
REQ-008 SHALL provide parameter ACCEL_THRESH, default 4, the number of consecutive fast same-direction steps needed to enter FAST mode.
REQ-009 SHALL provide parameter ACCEL_STEP, default 4, the step magnitude in FAST mode.
REQ-010 SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-011 SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-012 SHALL have port i_cnt, input, 1 bit: one-cycle step strobe from the quadrature decoder.
REQ-013 SHALL have port i_cnt_cw, input, 1 bit: step direction, 1 = clockwise (increment), qualified by i_cnt.
REQ-014 SHALL have port i_cnt_err, input, 1 bit: decoder error level or pulse.
REQ-015 SHALL have port i_clear, input, 1 bit: synchronous clear.
REQ-016 SHALL have port o_position, output, WIDTH bits: the current position.
REQ-017 SHALL have port o_err_count, output, ERR_WIDTH bits: the count of error events.
REQ-018 SHALL have ports o_at_min and o_at_max, output, 1 bit each: the position equals MIN_POS or MAX_POS (held 0 when WRAP=1).
REQ-019 SHALL have port o_step_valid, output, 1 bit: one-cycle pulse whenever o_position changes value.
REQ-020 SHALL have port o_fast, output, 1 bit: the FSM is in FAST.

Function
REQ-021 SHALL register o_position on the CLK edge that samples i_cnt=1, so the new value is visible in the next cycle; o_step_valid SHALL assert in that same cycle.
REQ-022 SHALL use a two-state FSM (SLOW, FAST); step magnitude SHALL be 1 in SLOW and ACCEL_STEP in FAST.
REQ-023 SHALL run a saturating interval timer that clears on every accepted step and stops at ACCEL_WINDOW.
REQ-024 SHALL increment a streak counter on each step arriving with timer < ACCEL_WINDOW in the same direction as the previous step; otherwise the streak SHALL restart at 1.
REQ-025 SHALL move SLOW->FAST when the streak reaches ACCEL_THRESH; the step that completes the streak SHALL still use magnitude 1.
REQ-026 SHALL move FAST->SLOW when the timer reaches ACCEL_WINDOW, or on a direction reversal; the reversing step SHALL use magnitude 1.
REQ-027 SHALL compute the next position in WIDTH+2 signed bits; when WRAP=1 it SHALL truncate modulo 2^WIDTH, and when WRAP=0 it SHALL clamp to [MIN_POS, MAX_POS].
REQ-028 SHALL NOT pulse o_step_valid when a saturating step leaves the position unchanged.
REQ-029 SHALL detect rising edges of i_cnt_err synchronously and increment o_err_count once per edge, saturating at all-ones; i_cnt_err SHALL NOT be used as a clock.
REQ-030 SHALL process a step and an error edge in the same cycle independently.
REQ-031 SHALL give i_clear priority: position <= RESET_POS, o_err_count <= 0, FSM <= SLOW, streak <= 0, timer <= ACCEL_WINDOW; a step in the same cycle SHALL be dropped, with no o_step_valid.

Reset
REQ-032 SHALL, while RST_N=0, force immediately and asynchronously: o_position=RESET_POS, o_err_count=0, o_step_valid=0, o_fast=0, FSM=SLOW, streak=0, timer=ACCEL_WINDOW, and the error edge-detect register=0.
REQ-033 SHALL accept the first step on the first rising CLK edge after RST_N is deasserted, with magnitude 1.

Structure
REQ-034 SHALL take the FSM state encodings (SLOW, FAST) and the default timing constants from the shared encoder definitions header.
REQ-035 SHALL place the timer, streak counter and FSM in one sub-module, encoder_accel_tracker, which outputs the step magnitude and o_fast.

Verification
(Bench parameters: WIDTH=8, WRAP=0, MIN_POS=0, MAX_POS=255, ACCEL_WINDOW=16, ACCEL_THRESH=3, ACCEL_STEP=4, RESET_POS=0.)
REQ-036 SHALL cover: reset, then 3 cw strobes spaced 20 cycles apart -> o_position=3, o_fast=0, three o_step_valid pulses.
REQ-037 SHALL cover: 4 cw strobes spaced 5 cycles apart -> o_position 1,2,3,7; o_fast=1 after the 3rd strobe; 20 idle cycles later -> o_fast=0.
REQ-038 SHALL cover: position 253 in FAST, cw strobe -> 255 with o_at_max=1; another cw strobe -> stays 255 with no o_step_valid; ccw strobe -> 254 and o_fast=0.
REQ-039 SHALL cover, with WRAP=1: position 255, slow cw strobe -> 0; slow ccw strobe -> 255; o_at_min and o_at_max stay 0.
REQ-040 SHALL cover: 17 i_cnt_err pulses, each 3 cycles high -> o_err_count=15; then i_clear together with i_cnt -> o_position=0, o_err_count=0, no o_step_valid.
REQ-041 SHALL cover: RST_N driven low mid-cycle while in FAST at position 100 -> o_position=0 and o_fast=0 before the next CLK edge.

Source files
------------

// File: rtl/encoder_position_pkg.sv
// Shared encoder definitions: FSM state encodings, default timing constants
// and a width helper used by the position tracker and its accel sub-block.
package encoder_position_pkg;

    // Accel FSM state encodings
    localparam logic [0:0] ST_SLOW = 1'b0;
    localparam logic [0:0] ST_FAST = 1'b1;

    // Default geometry and timing constants
    localparam int unsigned DEF_WIDTH        = 8;
    localparam int unsigned DEF_ERR_WIDTH    = 4;
    localparam int unsigned DEF_ACCEL_WINDOW = 500000;
    localparam int unsigned DEF_ACCEL_THRESH = 4;
    localparam int unsigned DEF_ACCEL_STEP   = 4;

    // Number of bits needed to hold values 0..max_val (at least 1)
    function automatic int unsigned bits_for(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while (w < 32 && (max_val >> w) != 0) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/encoder_accel_tracker.sv
// Step acceleration tracker: interval timer, same-direction streak counter
// and the SLOW/FAST FSM. Provides the magnitude for the step being sampled
// this cycle and a registered FAST indication.
//   clk, rst_n   : clock, async active-low reset
//   step, cw     : step strobe and its direction (1 = increment)
//   clear        : synchronous clear (wins over step)
//   step_mag_c   : magnitude for a step taken this cycle (combinational)
//   fast         : FSM is in FAST
module encoder_accel_tracker
    import encoder_position_pkg::*;
#(
    parameter int unsigned ACCEL_WINDOW = DEF_ACCEL_WINDOW,
    parameter int unsigned ACCEL_THRESH = DEF_ACCEL_THRESH,
    parameter int unsigned ACCEL_STEP   = DEF_ACCEL_STEP,
    parameter int unsigned MAG_W        = bits_for(DEF_ACCEL_STEP)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             cw,
    input  logic             clear,
    output logic [MAG_W-1:0] step_mag_c,
    output logic             fast
);

    localparam int unsigned TMR_W  = bits_for(ACCEL_WINDOW);
    localparam int unsigned STRK_W = bits_for(ACCEL_THRESH);

    localparam logic [TMR_W-1:0]  TMR_MAX  = TMR_W'(ACCEL_WINDOW);
    localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(ACCEL_THRESH);

    logic [0:0]        state, state_nxt;
    logic [TMR_W-1:0]  timer, timer_nxt;
    logic [STRK_W-1:0] streak, streak_nxt;
    logic              last_cw, last_cw_nxt;
    logic              quick;

    // Next-state, timer, streak and magnitude
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        streak_nxt  = streak;
        last_cw_nxt = last_cw;
        step_mag_c  = MAG_W'(1);
        // streak==0 means no prior step since reset/clear
        quick = (streak != '0) && (timer < TMR_MAX) && (cw == last_cw);

        if (clear) begin
            state_nxt  = ST_SLOW;
            timer_nxt  = TMR_MAX;
            streak_nxt = '0;
        end else if (step) begin
            timer_nxt   = '0;
            last_cw_nxt = cw;
            if (!quick) begin
                streak_nxt = STRK_W'(1);
            end else if (streak != STRK_MAX) begin
                streak_nxt = streak + STRK_W'(1);
            end
            case (state)
                ST_SLOW: begin
                    // The completing step itself still moves by 1
                    if (streak_nxt == STRK_MAX) begin
                        state_nxt = ST_FAST;
                    end
                end
                ST_FAST: begin
                    if (quick) begin
                        step_mag_c = MAG_W'(ACCEL_STEP);
                    end else begin
                        state_nxt = ST_SLOW;
                    end
                end
                default: state_nxt = ST_SLOW;
            endcase
        end else begin
            if (timer != TMR_MAX) begin
                timer_nxt = timer + TMR_W'(1);
            end
            if (state == ST_FAST && timer == TMR_MAX) begin
                state_nxt = ST_SLOW;
            end
        end
    end

    // State, timer and streak registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_SLOW;
            timer   <= TMR_MAX;
            streak  <= '0;
            last_cw <= 1'b0;
            fast    <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            streak  <= streak_nxt;
            last_cw <= last_cw_nxt;
            fast    <= (state_nxt == ST_FAST);
        end
    end

endmodule

// File: rtl/encoder_position.sv
// Quadrature position accumulator with step acceleration, wrap/saturate
// bounds and a saturating decoder error counter.
//   CLK, RST_N         : clock, async active-low reset
//   i_cnt, i_cnt_cw    : step strobe and direction (1 = increment)
//   i_cnt_err          : decoder error level/pulse, counted per rising edge
//   i_clear            : synchronous clear, drops a coincident step
//   o_position         : current position
//   o_err_count        : saturating error edge count
//   o_at_min, o_at_max : position at a saturation bound (0 when wrapping)
//   o_step_valid       : one-cycle pulse when o_position changes
//   o_fast             : accelerated stepping active
module encoder_position
    import encoder_position_pkg::*;
#(
    parameter int unsigned WIDTH        = DEF_WIDTH,
    parameter int unsigned ERR_WIDTH    = DEF_ERR_WIDTH,
    parameter int unsigned MIN_POS      = 0,
    parameter int unsigned MAX_POS      = 255,
    parameter int unsigned WRAP         = 0,
    parameter int unsigned RESET_POS    = 0,
    parameter int unsigned ACCEL_WINDOW = DEF_ACCEL_WINDOW,
    parameter int unsigned ACCEL_THRESH = DEF_ACCEL_THRESH,
    parameter int unsigned ACCEL_STEP   = DEF_ACCEL_STEP
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 i_cnt,
    input  logic                 i_cnt_cw,
    input  logic                 i_cnt_err,
    input  logic                 i_clear,
    output logic [WIDTH-1:0]     o_position,
    output logic [ERR_WIDTH-1:0] o_err_count,
    output logic                 o_at_min,
    output logic                 o_at_max,
    output logic                 o_step_valid,
    output logic                 o_fast
);

    localparam int unsigned MAG_W = bits_for(ACCEL_STEP);
    localparam int unsigned EXT_W = WIDTH + 2;

    localparam logic signed [EXT_W-1:0] MIN_EXT = EXT_W'(MIN_POS);
    localparam logic signed [EXT_W-1:0] MAX_EXT = EXT_W'(MAX_POS);

    localparam logic AT_MIN_RST = (WRAP == 0) && (RESET_POS == MIN_POS);
    localparam logic AT_MAX_RST = (WRAP == 0) && (RESET_POS == MAX_POS);

    logic [MAG_W-1:0]        step_mag_c;
    logic signed [EXT_W-1:0] pos_ext, mag_ext, pos_sum;
    logic [WIDTH-1:0]        pos_step, pos_upd;
    logic                    err_d;
    logic                    err_rise;

    encoder_accel_tracker #(
        .ACCEL_WINDOW (ACCEL_WINDOW),
        .ACCEL_THRESH (ACCEL_THRESH),
        .ACCEL_STEP   (ACCEL_STEP),
        .MAG_W        (MAG_W)
    ) u_accel (
        .clk        (CLK),
        .rst_n      (RST_N),
        .step       (i_cnt),
        .cw         (i_cnt_cw),
        .clear      (i_clear),
        .step_mag_c (step_mag_c),
        .fast       (o_fast)
    );

    // Signed next-position with wrap or clamp; two guard bits cover both overflow directions
    always_comb begin
        pos_ext  = signed'(EXT_W'(o_position));
        mag_ext  = signed'(EXT_W'(step_mag_c));
        pos_sum  = i_cnt_cw ? (pos_ext + mag_ext) : (pos_ext - mag_ext);
        pos_step = pos_sum[WIDTH-1:0];
        if (WRAP == 0) begin
            if (pos_sum < MIN_EXT) begin
                pos_step = WIDTH'(MIN_POS);
            end else if (pos_sum > MAX_EXT) begin
                pos_step = WIDTH'(MAX_POS);
            end
        end
        pos_upd = o_position;
        if (i_clear) begin
            pos_upd = WIDTH'(RESET_POS);
        end else if (i_cnt) begin
            pos_upd = pos_step;
        end
    end

    assign err_rise = i_cnt_err & ~err_d;

    // Position, flags and error counter registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            o_position   <= WIDTH'(RESET_POS);
            o_err_count  <= '0;
            o_at_min     <= AT_MIN_RST;
            o_at_max     <= AT_MAX_RST;
            o_step_valid <= 1'b0;
            err_d        <= 1'b0;
        end else begin
            err_d        <= i_cnt_err;
            o_position   <= pos_upd;
            o_step_valid <= !i_clear && i_cnt && (pos_step != o_position);
            o_at_min     <= (WRAP == 0) && (pos_upd == WIDTH'(MIN_POS));
            o_at_max     <= (WRAP == 0) && (pos_upd == WIDTH'(MAX_POS));
            if (i_clear) begin
                o_err_count <= '0;
            end else if (err_rise && (o_err_count != '1)) begin
                o_err_count <= o_err_count + ERR_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_encoder_position.sv
// Bench for encoder_position: a saturating and a wrapping instance share the
// same stimulus; both are compared every cycle to a gap-based reference model,
// plus directed scenario checks with hand-derived constants.
module tb_encoder_position;

    localparam int W    = 8;
    localparam int EW   = 4;
    localparam int MINP = 0;
    localparam int MAXP = 255;
    localparam int WIN  = 16;
    localparam int THR  = 3;
    localparam int STP  = 4;
    localparam int RSTP = 0;
    localparam int EMAX = 15;

    logic clk, rst_n;
    logic cnt, cnt_cw, cnt_err, clear;
    logic [W-1:0]  pos_s, pos_w;
    logic [EW-1:0] err_s, err_w;
    logic at_min_s, at_max_s, sv_s, fast_s;
    logic at_min_w, at_max_w, sv_w, fast_w;

    int checks   = 0;
    int failures = 0;
    int sv_seen  = 0;

    encoder_position #(
        .WIDTH(W), .ERR_WIDTH(EW), .MIN_POS(MINP), .MAX_POS(MAXP), .WRAP(0),
        .RESET_POS(RSTP), .ACCEL_WINDOW(WIN), .ACCEL_THRESH(THR), .ACCEL_STEP(STP)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .i_cnt(cnt), .i_cnt_cw(cnt_cw),
        .i_cnt_err(cnt_err), .i_clear(clear), .o_position(pos_s),
        .o_err_count(err_s), .o_at_min(at_min_s), .o_at_max(at_max_s),
        .o_step_valid(sv_s), .o_fast(fast_s)
    );

    encoder_position #(
        .WIDTH(W), .ERR_WIDTH(EW), .MIN_POS(MINP), .MAX_POS(MAXP), .WRAP(1),
        .RESET_POS(RSTP), .ACCEL_WINDOW(WIN), .ACCEL_THRESH(THR), .ACCEL_STEP(STP)
    ) dut_w (
        .CLK(clk), .RST_N(rst_n), .i_cnt(cnt), .i_cnt_cw(cnt_cw),
        .i_cnt_err(cnt_err), .i_clear(clear), .o_position(pos_w),
        .o_err_count(err_w), .o_at_min(at_min_w), .o_at_max(at_max_w),
        .o_step_valid(sv_w), .o_fast(fast_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: acceleration decided from cycle gaps between steps
    int m_pos [2];
    bit m_sv  [2];
    int m_err;
    bit m_fast;
    int m_streak;
    bit m_have_prev;
    bit m_last_cw;
    int m_last_cyc;
    int m_cyc;
    bit m_prev_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int w = 0; w < 2; w++) begin
            m_pos[w] = RSTP;
            m_sv[w]  = 1'b0;
        end
        m_err       = 0;
        m_fast      = 1'b0;
        m_streak    = 0;
        m_have_prev = 1'b0;
        m_prev_err  = 1'b0;
    endfunction

    function automatic void model_step();
        int gap, mag, nxt;
        bit quick;
        m_cyc++;
        m_sv[0] = 1'b0;
        m_sv[1] = 1'b0;
        if (clear) begin
            m_pos[0]    = RSTP;
            m_pos[1]    = RSTP;
            m_err       = 0;
            m_fast      = 1'b0;
            m_streak    = 0;
            m_have_prev = 1'b0;
        end else begin
            gap = m_cyc - m_last_cyc;
            if (cnt) begin
                quick    = m_have_prev && (gap <= WIN) && (cnt_cw == m_last_cw);
                mag      = (m_fast && quick) ? STP : 1;
                m_streak = quick ? m_streak + 1 : 1;
                m_fast   = m_fast ? quick : (m_streak >= THR);
                m_have_prev = 1'b1;
                m_last_cw   = cnt_cw;
                m_last_cyc  = m_cyc;
                for (int w = 0; w < 2; w++) begin
                    nxt = cnt_cw ? m_pos[w] + mag : m_pos[w] - mag;
                    if (w == 1) begin
                        nxt = ((nxt % 256) + 256) % 256;
                    end else begin
                        if (nxt < MINP) nxt = MINP;
                        if (nxt > MAXP) nxt = MAXP;
                    end
                    m_sv[w]  = (nxt != m_pos[w]);
                    m_pos[w] = nxt;
                end
            end else if (m_fast && gap > WIN) begin
                m_fast = 1'b0;
            end
            if (cnt_err && !m_prev_err && m_err < EMAX) m_err++;
        end
        m_prev_err = cnt_err;
    endfunction

    task automatic compare_all();
        check("pos_sat",    pos_s,    m_pos[0]);
        check("pos_wrap",   pos_w,    m_pos[1]);
        check("sv_sat",     sv_s,     m_sv[0]);
        check("sv_wrap",    sv_w,     m_sv[1]);
        check("fast_sat",   fast_s,   m_fast);
        check("fast_wrap",  fast_w,   m_fast);
        check("err_sat",    err_s,    m_err);
        check("err_wrap",   err_w,    m_err);
        check("at_min_sat", at_min_s, (m_pos[0] == MINP));
        check("at_max_sat", at_max_s, (m_pos[0] == MAXP));
        check("at_min_wrap", at_min_w, 1'b0);
        check("at_max_wrap", at_max_w, 1'b0);
    endtask

    // One clock: model follows the sampled inputs, outputs checked at negedge
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
        compare_all();
        if (sv_s) sv_seen++;
    endtask

    task automatic idle(input int n);
        cnt = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input bit dir);
        cnt    = 1'b1;
        cnt_cw = dir;
        tick();
        cnt    = 1'b0;
    endtask

    task automatic strobe_gap(input bit dir, input int gap);
        strobe(dir);
        idle(gap - 1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        int g;
        rst_n = 1'b0; cnt = 1'b0; cnt_cw = 1'b0; cnt_err = 1'b0; clear = 1'b0;
        m_cyc = 0; m_last_cyc = 0; m_last_cw = 1'b0;
        model_reset();
        tick();
        tick();
        check("rst_pos", pos_s, 0);
        check("rst_fast", fast_s, 0);
        rst_n = 1'b1;

        // Slow stepping: three cw strobes 20 cycles apart
        sv_seen = 0;
        for (int i = 0; i < 3; i++) strobe_gap(1'b1, 20);
        check("s1_pos", pos_s, 3);
        check("s1_fast", fast_s, 0);
        check("s1_pulses", sv_seen, 3);

        // Acceleration entry and timeout
        do_clear();
        strobe(1'b1); check("s2_p1", pos_s, 1); idle(4);
        strobe(1'b1); check("s2_p2", pos_s, 2); check("s2_fast2", fast_s, 0); idle(4);
        strobe(1'b1); check("s2_p3", pos_s, 3); check("s2_fast3", fast_s, 1); idle(4);
        strobe(1'b1); check("s2_p4", pos_s, 7);
        idle(20);
        check("s2_timeout", fast_s, 0);

        // Saturation at MAX_POS while FAST, then reversal
        do_clear();
        strobe_gap(1'b1, 20);
        strobe_gap(1'b1, 20);
        for (int i = 0; i < 3; i++) strobe_gap(1'b1, 5);
        for (int i = 0; i < 62; i++) strobe_gap(1'b1, $urandom_range(1, WIN));
        check("s3_253", pos_s, 253);
        check("s3_fast", fast_s, 1);
        strobe(1'b1);
        check("s3_255", pos_s, 255);
        check("s3_atmax", at_max_s, 1);
        check("s3_sv", sv_s, 1);
        idle($urandom_range(0, 10));
        strobe(1'b1);
        check("s3_hold", pos_s, 255);
        check("s3_nosv", sv_s, 0);
        idle($urandom_range(0, 10));
        strobe(1'b0);
        check("s3_rev", pos_s, 254);
        check("s3_rev_fast", fast_s, 0);

        // Wrap instance around 0/255
        do_clear();
        strobe_gap(1'b0, 20);
        check("s4_wrap_dn", pos_w, 255);
        check("s4_sat_dn", pos_s, 0);
        strobe_gap(1'b1, 20);
        check("s4_wrap_up", pos_w, 0);
        check("s4_wrap_min", at_min_w, 0);
        strobe_gap(1'b0, 20);
        check("s4_wrap_dn2", pos_w, 255);
        check("s4_wrap_max", at_max_w, 0);

        // Error counter saturation, then clear with coincident step
        for (int i = 0; i < 3; i++) strobe_gap(1'b1, 20);
        for (int i = 0; i < 17; i++) begin
            cnt_err = 1'b1;
            idle(3);
            cnt_err = 1'b0;
            idle($urandom_range(1, 3));
        end
        check("s5_err_sat", err_s, 15);
        clear = 1'b1; cnt = 1'b1; cnt_cw = 1'b1;
        tick();
        clear = 1'b0; cnt = 1'b0;
        check("s5_clr_pos", pos_s, 0);
        check("s5_clr_err", err_s, 0);
        check("s5_clr_sv", sv_s, 0);

        // Asynchronous reset mid-cycle while FAST at 100
        do_clear();
        strobe_gap(1'b1, 20);
        for (int i = 0; i < 3; i++) strobe_gap(1'b1, 5);
        for (int i = 0; i < 24; i++) strobe_gap(1'b1, $urandom_range(1, WIN));
        check("s6_pos", pos_s, 100);
        check("s6_fast", fast_s, 1);
        #2 rst_n = 1'b0;
        #1;
        check("s6_async_pos", pos_s, 0);
        check("s6_async_fast", fast_s, 0);
        check("s6_async_wpos", pos_w, 0);
        tick();
        rst_n = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 2500; i++) begin
            cnt = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) cnt_cw = ~cnt_cw;
            if ($urandom_range(0, 4) == 0) cnt_err = ~cnt_err;
            clear = ($urandom_range(0, 249) == 0);
            tick();
            if ($urandom_range(0, 99) == 0) begin
                g = $urandom_range(10, 25);
                clear = 1'b0;
                idle(g);
            end
        end
        cnt = 1'b0; clear = 1'b0; cnt_err = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
